// File: rtl/spi_master.sv
// Byte-wide SPI mode-0 master (MSB first) with a one-entry receive buffer.
// A transfer takes 16*HalfPeriod cycles from accept to received byte; if_din is stalled while busy.
module spi_master #(
    parameter int ClockFrequency = 15_000_000,
    parameter int SclkFrequency  = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       if_din_valid,
    output logic       if_din_ready,
    input  logic [7:0] if_din_bits,
    output logic       if_dout_valid,
    input  logic       if_dout_ready,
    output logic [7:0] if_dout_bits,
    input  logic       if_ctrl_valid,
    output logic       if_ctrl_ready,
    input  logic [7:0] if_ctrl_bits,
    output logic       o_sclk,
    output logic       o_mosi,
    input  logic       i_miso,
    output logic       o_cs_n,
    output logic       o_busy,
    output logic       o_overrun
);
    localparam int HalfRaw    = ClockFrequency / (2 * SclkFrequency);
    localparam int HalfPeriod = (HalfRaw < 1) ? 1 : HalfRaw;
    localparam int DivW       = (HalfPeriod > 1) ? $clog2(HalfPeriod) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(HalfPeriod - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic [7:0]      rx_buf_q, rx_buf_d;
    logic            rx_vld_q, rx_vld_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            cs_n_q, cs_n_d;
    logic            ovr_q, ovr_d;
    logic            done;
    logic            rd;
    logic            ctrl_unused;

    assign ctrl_unused = ^if_ctrl_bits[7:1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_sh_q  <= '0;
            rx_buf_q <= '0;
            rx_vld_q <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_sh_q  <= rx_sh_d;
            rx_buf_q <= rx_buf_d;
            rx_vld_q <= rx_vld_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cs_n_q   <= cs_n_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_sh_d  = rx_sh_q;
        rx_buf_d = rx_buf_q;
        rx_vld_d = rx_vld_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        ovr_d    = ovr_q;
        done     = 1'b0;
        rd       = rx_vld_q & if_dout_ready;

        case (state_q)
            IDLE: begin
                if (if_din_valid) begin
                    tx_d    = if_din_bits;
                    mosi_d  = if_din_bits[7];
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (div_q == DivLast) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[6:0], i_miso};
                    state_d = HIGH;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HIGH: begin
                if (div_q == DivLast) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = {tx_q[6:0], 1'b0};
                        mosi_d  = tx_q[6];
                        state_d = LOW;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A read in the completion cycle takes the old byte, so it is not an overrun.
        if (done) begin
            rx_buf_d = rx_sh_q;
            rx_vld_d = 1'b1;
            if (rx_vld_q && !rd) begin
                ovr_d = 1'b1;
            end
        end else if (rd) begin
            rx_vld_d = 1'b0;
        end

        if (if_ctrl_valid) begin
            cs_n_d = ~if_ctrl_bits[0];
        end
    end

    assign if_din_ready  = (state_q == IDLE);
    assign if_dout_valid = rx_vld_q;
    assign if_dout_bits  = rx_buf_q;
    assign if_ctrl_ready = 1'b1;
    assign o_sclk        = sclk_q;
    assign o_mosi        = mosi_q;
    assign o_cs_n        = cs_n_q;
    assign o_busy        = (state_q != IDLE);
    assign o_overrun     = ovr_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master at HalfPeriod=2 with a mode-0 slave model on i_miso.
module tb_spi_master;
    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       if_din_valid, if_din_ready;
    logic [7:0] if_din_bits;
    logic       if_dout_valid, if_dout_ready;
    logic [7:0] if_dout_bits;
    logic       if_ctrl_valid, if_ctrl_ready;
    logic [7:0] if_ctrl_bits;
    logic       o_sclk, o_mosi, i_miso, o_cs_n, o_busy, o_overrun;

    spi_master #(.ClockFrequency(4_000_000), .SclkFrequency(1_000_000)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .if_din_valid(if_din_valid), .if_din_ready(if_din_ready), .if_din_bits(if_din_bits),
        .if_dout_valid(if_dout_valid), .if_dout_ready(if_dout_ready), .if_dout_bits(if_dout_bits),
        .if_ctrl_valid(if_ctrl_valid), .if_ctrl_ready(if_ctrl_ready), .if_ctrl_bits(if_ctrl_bits),
        .o_sclk(o_sclk), .o_mosi(o_mosi), .i_miso(i_miso), .o_cs_n(o_cs_n),
        .o_busy(o_busy), .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Slave model: loads its byte when a transfer is accepted, shifts on SCLK fall,
    // and records MOSI at each SCLK rise plus the number of high-phase cycles.
    logic [7:0] slv_next, slv_sh, mosi_cap;
    logic       prev_sclk;
    int         rise_cnt, hi_cnt;
    assign i_miso = slv_sh[7];

    always @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            slv_sh <= '0; prev_sclk <= 1'b0; rise_cnt <= 0; hi_cnt <= 0; mosi_cap <= '0;
        end else if (if_din_valid && if_din_ready) begin
            slv_sh <= slv_next; prev_sclk <= o_sclk; rise_cnt <= 0; hi_cnt <= 0; mosi_cap <= '0;
        end else begin
            prev_sclk <= o_sclk;
            if (o_sclk) hi_cnt <= hi_cnt + 1;
            if (o_sclk && !prev_sclk) begin
                rise_cnt <= rise_cnt + 1;
                mosi_cap <= {mosi_cap[6:0], o_mosi};
            end
            if (!o_sclk && prev_sclk) slv_sh <= {slv_sh[6:0], 1'b0};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        if_din_valid = 1'b0; if_din_bits = '0; if_dout_ready = 1'b0;
        if_ctrl_valid = 1'b0; if_ctrl_bits = '0; slv_next = '0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    task automatic start(input logic [7:0] b, input logic [7:0] s, output int t, output int waited);
        slv_next = s; if_din_bits = b; if_din_valid = 1'b1; waited = 0;
        while (waited < 200) begin
            @(negedge i_clk);
            if (if_din_ready) break;
            waited++;
        end
        if (waited >= 200) check("din_accept_timeout", 32'(waited), 0);
        @(posedge i_clk); #1;
        if_din_valid = 1'b0;
        t = cyc;
    endtask

    task automatic wait_done(output int t);
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge i_clk); #1;
            if (!o_busy) break;
        end
        if (k >= 200) check("done_timeout", 32'(k), 0);
        t = cyc;
    endtask

    task automatic read_byte(input string nm, input logic [31:0] exp);
        @(negedge i_clk);
        check({nm, "_vld"}, 32'(if_dout_valid), 1);
        check({nm, "_dat"}, 32'(if_dout_bits), exp);
        if_dout_ready = 1'b1;
        @(posedge i_clk); #1;
        if_dout_ready = 1'b0;
        check({nm, "_clr"}, 32'(if_dout_valid), 0);
    endtask

    task automatic ctrl_write(input logic [7:0] b);
        if_ctrl_bits = b; if_ctrl_valid = 1'b1;
        @(posedge i_clk); #1;
        if_ctrl_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] slv;
        logic [7:0] exp_rx;
        logic [7:0] exp_mosi;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int ta, td, ta2, w, seen;
        vecs[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[1] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
        vecs[2] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[3] = '{8'h80, 8'h01, 8'h01, 8'h80};

        do_reset();
        check("rst_sclk", 32'(o_sclk), 0);
        check("rst_mosi", 32'(o_mosi), 0);
        check("rst_cs_n", 32'(o_cs_n), 1);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_ovr", 32'(o_overrun), 0);
        check("rst_dvld", 32'(if_dout_valid), 0);
        check("rst_dbits", 32'(if_dout_bits), 0);
        check("rst_din_rdy", 32'(if_din_ready), 1);
        check("rst_ctrl_rdy", 32'(if_ctrl_ready), 1);

        for (int i = 0; i < 4; i++) begin
            start(vecs[i].tx, vecs[i].slv, ta, w);
            check("vec_busy_rise", 32'(o_busy), 1);
            check("vec_din_rdy_low", 32'(if_din_ready), 0);
            wait_done(td);
            check("vec_latency", 32'(td - ta), 32);
            check("vec_dvld_at_done", 32'(if_dout_valid), 1);
            check("vec_rx", 32'(if_dout_bits), 32'(vecs[i].exp_rx));
            check("vec_mosi_bits", 32'(mosi_cap), 32'(vecs[i].exp_mosi));
            check("vec_sclk_pulses", 32'(rise_cnt), 8);
            check("vec_sclk_high_cycles", 32'(hi_cnt), 16);
            check("vec_sclk_idle", 32'(o_sclk), 0);
            read_byte("vec_read", 32'(vecs[i].exp_rx));
        end
        check("vec_mosi_hold", 32'(o_mosi), 0);

        // Back-to-back offer: second byte waits for IDLE, first byte read mid-transfer.
        start(8'h11, 8'hC1, ta, w);
        start(8'h22, 8'hC2, ta2, w);
        check("b2b_gap", 32'(ta2 - ta), 33);
        check("b2b_stalled", 32'(w > 0), 1);
        read_byte("b2b_rd1", 32'hC1);
        wait_done(td);
        check("b2b_latency", 32'(td - ta2), 32);
        read_byte("b2b_rd2", 32'hC2);
        check("b2b_no_ovr", 32'(o_overrun), 0);

        // Overrun: two completions without a read.
        start(8'h10, 8'h01, ta, w);
        wait_done(td);
        start(8'h20, 8'h02, ta, w);
        wait_done(td);
        check("ovr_set", 32'(o_overrun), 1);
        check("ovr_bits", 32'(if_dout_bits), 32'h02);
        read_byte("ovr_rd", 32'h02);
        check("ovr_sticky", 32'(o_overrun), 1);

        // Read coinciding with completion.
        do_reset();
        start(8'h30, 8'h55, ta, w);
        wait_done(td);
        start(8'h40, 8'h66, ta, w);
        while (cyc < ta + 31) begin @(posedge i_clk); #1; end
        if_dout_ready = 1'b1;
        @(negedge i_clk);
        check("sim_old_vld", 32'(if_dout_valid), 1);
        check("sim_old_bits", 32'(if_dout_bits), 32'h55);
        check("sim_busy_before", 32'(o_busy), 1);
        @(posedge i_clk); #1;
        if_dout_ready = 1'b0;
        check("sim_busy_after", 32'(o_busy), 0);
        check("sim_new_vld", 32'(if_dout_valid), 1);
        check("sim_new_bits", 32'(if_dout_bits), 32'h66);
        check("sim_no_ovr", 32'(o_overrun), 0);
        read_byte("sim_rd", 32'h66);

        // Chip select control, idle and mid-transfer.
        ctrl_write(8'h01);
        check("cs_assert", 32'(o_cs_n), 0);
        ctrl_write(8'hFE);
        check("cs_deassert", 32'(o_cs_n), 1);
        start(8'h5A, 8'hC3, ta, w);
        repeat (5) begin @(posedge i_clk); #1; end
        ctrl_write(8'h01);
        check("cs_mid_xfer", 32'(o_cs_n), 0);
        wait_done(td);
        check("cs_xfer_latency", 32'(td - ta), 32);
        check("cs_xfer_pulses", 32'(rise_cnt), 8);
        check("cs_xfer_high", 32'(hi_cnt), 16);
        check("cs_xfer_mosi", 32'(mosi_cap), 32'h5A);
        read_byte("cs_xfer_rd", 32'hC3);

        // Asynchronous reset after the third SCLK rise.
        start(8'h96, 8'h69, ta, w);
        seen = 0;
        while (rise_cnt < 3 && seen < 100) begin @(negedge i_clk); seen++; end
        check("mid_rst_reached", 32'(rise_cnt >= 3), 1);
        #2 i_rst = 1'b1;
        #1;
        check("mid_rst_sclk", 32'(o_sclk), 0);
        check("mid_rst_mosi", 32'(o_mosi), 0);
        check("mid_rst_cs_n", 32'(o_cs_n), 1);
        check("mid_rst_busy", 32'(o_busy), 0);
        check("mid_rst_ovr", 32'(o_overrun), 0);
        check("mid_rst_dvld", 32'(if_dout_valid), 0);
        check("mid_rst_dbits", 32'(if_dout_bits), 0);
        @(posedge i_clk); #1 i_rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge i_clk); #1;
            if (if_dout_valid || o_busy) seen++;
        end
        check("mid_rst_quiet", 32'(seen), 0);
        start(8'hFF, 8'h81, ta, w);
        wait_done(td);
        check("post_rst_latency", 32'(td - ta), 32);
        check("post_rst_mosi", 32'(mosi_cap), 32'hFF);
        check("post_rst_pulses", 32'(rise_cnt), 8);
        read_byte("post_rst_rd", 32'h81);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-wide SPI master (mode 0: CPOL=0, CPHA=0, MSB first) for the peripheral I/O bus.
- Attaches downstream of the bus device-select logic:
  - the bus routes an out-instruction byte to if_din;
  - an in-instruction read drains the received byte from if_dout;
  - writes on if_ctrl drive chip select.
- Drives the board o_sclk/o_mosi/o_cs_n pins and samples i_miso.

Parameters:
- ClockFrequency, 15_000_000: i_clk frequency in Hz.
- SclkFrequency, 1_000_000: target SCLK frequency in Hz.
- HalfPeriod, max(1, ClockFrequency/(2*SclkFrequency)) (floor division): i_clk cycles per SCLK half period. Derived localparam, not overridable.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset, asynchronous, active-high.
- if_din  Decoupled.receiver  8  byte to transmit; one transfer starts per accepted byte.
- if_dout  Decoupled.sender  8  last received byte.
- if_ctrl  Decoupled.receiver  8  control write; bit0=1 asserts chip select; bits7:1 ignored.
- o_sclk  output  1  SPI clock, idles low.
- o_mosi  output  1  SPI data out.
- i_miso  input  1  SPI data in; no synchronizer, sampled directly on the internal SCLK rising edge.
- o_cs_n  output  1  chip select, active-low.
- o_busy  output  1  high while a transfer is in progress.
- o_overrun  output  1  sticky; set when a received byte overwrites an unread byte.

Behaviour:
- Clock and reset: one clock (i_clk); reset is asynchronous and active-high (i_rst).
- Reset values: o_sclk=0, o_mosi=0, o_cs_n=1, o_busy=0, o_overrun=0, if_dout.valid=0, if_dout.bits=0, state=IDLE, divider=0, bit counter=0.
- State machine: IDLE, LOW, HIGH.
  - IDLE: if_din.ready=1. On if_din.valid&ready:
    - load shift register with bits;
    - o_mosi=bits[7] on the next edge;
    - bit counter=0, divider=0; go to LOW; o_busy=1.
  - LOW: o_sclk=0. When divider==HalfPeriod-1:
    - divider=0; o_sclk<=1;
    - capture i_miso into receive shift LSB;
    - go to HIGH.
  - HIGH: o_sclk=1. When divider==HalfPeriod-1:
    - divider=0; o_sclk<=0;
    - if bit counter==7: load receive byte into the rx buffer and go to IDLE (o_busy=0);
    - else: increment bit counter, shift the transmit register left, o_mosi<=next bit, go to LOW.
- Latency: if_din accepted at edge T → o_busy high at T → rx buffer valid and o_busy low at edge T+16*HalfPeriod.
  - Each SCLK phase lasts exactly HalfPeriod cycles.
  - Next if_din accept is possible in the cycle after return to IDLE.
- if_din.ready=0 in LOW/HIGH; data offered then is held by the producer (not dropped).
- rx buffer (1 entry):
  - if_dout.valid=1 while full; if_dout.bits stable while valid.
  - Cleared on if_dout.valid&ready.
  - Completion while still full: buffer overwritten, o_overrun<=1 (sticky until reset).
  - Completion and read in the same cycle: the read takes the old byte, the buffer holds the new byte, no overrun.
- if_ctrl:
  - ready=1 always; on valid, o_cs_n<=~bits[0] at the next edge, also mid-transfer (no interlock).
  - Software sequencing is responsible for CS timing.
- o_mosi keeps its last value in IDLE.
- Reset mid-transfer: immediate return to reset values; a partial byte is discarded.
- HalfPeriod=1 is legal: SCLK = i_clk/2.

Test Plan:
- Timing: HalfPeriod=2 (ClockFrequency=4_000_000, SclkFrequency=1_000_000); write 0xA5, i_miso tied to a slave model returning 0x3C.
  - MOSI bits 1,0,1,0,0,1,0,1 stable on each SCLK rising edge.
  - Exactly 8 SCLK pulses of 4 i_clk cycles each.
  - if_dout.valid with bits 0x3C exactly 32 cycles after accept; o_busy falls in the same cycle.
- Back-pressure: offer 0x11 then 0x22 back-to-back.
  - Second byte has ready=0 until IDLE; accepted on the first IDLE cycle; two full transfers.
  - Read after each transfer returns slave bytes in order.
- Overrun: two transfers (slave returns 0x01 then 0x02), no reads.
  - o_overrun=1; if_dout.bits=0x02.
  - Next read clears valid; o_overrun stays 1.
- Simultaneous read and completion: hold if_dout.ready=1 during the second transfer's last cycle.
  - Old byte consumed; new byte valid next cycle; o_overrun=0.
- Control: if_ctrl write 0x01 → o_cs_n=0 next cycle; write 0xFE → o_cs_n=1.
  - Write during a transfer takes effect without disturbing SCLK.
- Reset mid-transfer: assert i_rst after the 3rd SCLK rise.
  - All outputs return to reset values asynchronously, without waiting for an i_clk edge.
  - No if_dout.valid afterwards.
  - A new 0xFF transfer works normally.
